// File: rtl/snake_dir_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : snake_dir_ctrl
// Brief    : Debounced 4-button heading control with a periodic move tick.
//            Optional macro SNAKE_REVERSE_LOCK_EN discards presses opposite
//            to the committed heading.
// Revision : 1.0 - initial release
//==============================================================================
module snake_dir_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int MOVE_PERIOD     = 15000000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       run,
   input  logic       BtnU,
   input  logic       BtnD,
   input  logic       BtnL,
   input  logic       BtnR,
   output logic [1:0] dir,
   output logic       move_tick,
   output logic       dir_changed
);

   localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int c_MV_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;

   localparam logic [c_DB_W-1:0] c_DB_MAX  = c_DB_W'(DEBOUNCE_CYCLES);
   localparam logic [c_DB_W-1:0] c_DB_ARM  = c_DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_MV_W-1:0] c_MV_LAST = c_MV_W'(MOVE_PERIOD - 1);

   localparam logic [1:0] c_DIR_UP    = 2'b00;
   localparam logic [1:0] c_DIR_DOWN  = 2'b01;
   localparam logic [1:0] c_DIR_LEFT  = 2'b10;
   localparam logic [1:0] c_DIR_RIGHT = 2'b11;

   // Button bit order: 0 = up, 1 = down, 2 = left, 3 = right
   logic [3:0]        w_btn_raw;
   logic [3:0]        r_sync1;
   logic [3:0]        r_sync2;
   logic [3:0]        w_press;
   logic              w_sel_valid;
   logic [1:0]        w_sel_dir;
   logic              w_reverse;
   logic              w_accept;
   logic              w_tick_due;
   logic [c_MV_W-1:0] r_move_cnt;
   logic [1:0]        r_pending;
   logic [1:0]        r_dir;
   logic              r_move_tick;
   logic              r_dir_changed;

   assign w_btn_raw = {BtnR, BtnL, BtnD, BtnU};

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
         logic [c_DB_W-1:0] r_db_cnt;
         logic              r_press_pulse;

         // Pulse is registered so it lines up with the counter reaching max
         always_ff @(posedge Clk) begin
            if (Reset) begin
               r_db_cnt      <= '0;
               r_press_pulse <= 1'b0;
            end else if (r_sync2[gi]) begin
               if (r_db_cnt != c_DB_MAX) begin
                  r_db_cnt <= r_db_cnt + 1'b1;
               end
               r_press_pulse <= (r_db_cnt == c_DB_ARM);
            end else begin
               r_db_cnt      <= '0;
               r_press_pulse <= 1'b0;
            end
         end

         assign w_press[gi] = r_press_pulse;
      end
   endgenerate

   always_comb begin
      w_sel_valid = |w_press;
      w_sel_dir   = c_DIR_RIGHT;
      if (w_press[0]) begin
         w_sel_dir = c_DIR_UP;
      end else if (w_press[1]) begin
         w_sel_dir = c_DIR_DOWN;
      end else if (w_press[2]) begin
         w_sel_dir = c_DIR_LEFT;
      end
   end

`ifdef SNAKE_REVERSE_LOCK_EN
   // Opposite headings differ only in bit 0
   assign w_reverse = ((w_sel_dir ^ r_dir) == 2'b01);
`else
   assign w_reverse = 1'b0;
`endif

   assign w_accept   = run & w_sel_valid & ~w_reverse;
   assign w_tick_due = run & (r_move_cnt == c_MV_LAST);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_move_cnt <= '0;
      end else if (!run || w_tick_due) begin
         r_move_cnt <= '0;
      end else begin
         r_move_cnt <= r_move_cnt + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_pending <= c_DIR_RIGHT;
      end else if (w_accept) begin
         r_pending <= w_sel_dir;
      end
   end

   // Commit uses the pending value held before this edge's press update
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_dir         <= c_DIR_RIGHT;
         r_move_tick   <= 1'b0;
         r_dir_changed <= 1'b0;
      end else begin
         r_move_tick   <= w_tick_due;
         r_dir_changed <= w_tick_due & (r_pending != r_dir);
         if (w_tick_due) begin
            r_dir <= r_pending;
         end
      end
   end

   assign dir         = r_dir;
   assign move_tick   = r_move_tick;
   assign dir_changed = r_dir_changed;

endmodule
`default_nettype wire

// File: tb/tb_snake_dir_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_snake_dir_ctrl
// Brief    : Directed bench for snake_dir_ctrl with an expected-tick queue.
// Revision : 1.0 - initial release
//==============================================================================
module tb_snake_dir_ctrl;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       run;
   logic       BtnU;
   logic       BtnD;
   logic       BtnL;
   logic       BtnR;
   logic [1:0] dir;
   logic       move_tick;
   logic       dir_changed;

   typedef struct packed {
      logic [31:0] cyc;
      logic [1:0]  dir;
      logic        chg;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc    = 0;
   int unsigned t0;
   int unsigned t1;
   logic [1:0]  rev_dir;
   logic        rev_chg;

   snake_dir_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .MOVE_PERIOD    (10)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .run        (run),
      .BtnU       (BtnU),
      .BtnD       (BtnD),
      .BtnL       (BtnL),
      .BtnR       (BtnR),
      .dir        (dir),
      .move_tick  (move_tick),
      .dir_changed(dir_changed)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int unsigned c, input logic [1:0] d, input logic g);
      exp_t e;
      e.cyc = c;
      e.dir = d;
      e.chg = g;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      run   = 1'b0;
      BtnU  = 1'b0;
      BtnD  = 1'b0;
      BtnL  = 1'b0;
      BtnR  = 1'b0;
      repeat (3) @(negedge Clk);
      chk("rst_dir", 32'(dir), 32'd3);
      chk("rst_pending", 32'(dut.r_pending), 32'd3);
      chk("rst_tick", 32'(move_tick), 32'd0);
      chk("rst_move_cnt", 32'(dut.r_move_cnt), 32'd0);
      Reset = 1'b0;
   endtask

   // Every tick must match the head of the expected queue
   always @(negedge Clk) begin
      exp_t e;
      if (move_tick) begin
         if (sb.size() == 0) begin
            checks++;
            assert (0) else begin
               errors++;
               $error("FAIL unexpected_tick: observed=tick at cycle %0d expected=no tick", cyc);
            end
         end else begin
            e = sb.pop_front();
            chk("tick_cycle", cyc, e.cyc);
            chk("tick_dir", 32'(dir), 32'(e.dir));
            chk("tick_changed", 32'(dir_changed), 32'(e.chg));
         end
      end
      if (dir_changed) begin
         chk("changed_needs_tick", 32'(move_tick), 32'd1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset = 1'b1;
      run   = 1'b0;
      BtnU  = 1'b0;
      BtnD  = 1'b0;
      BtnL  = 1'b0;
      BtnR  = 1'b0;
      @(negedge Clk);
      do_reset();
      chk("rst_changed", 32'(dir_changed), 32'd0);

      // Idle run: heading stays right, ticks every 10 clocks
      run = 1'b1;
      t0  = cyc;
      push(t0 + 10, 2'b11, 1'b0);
      push(t0 + 20, 2'b11, 1'b0);
      push(t0 + 30, 2'b11, 1'b0);
      repeat (35) @(negedge Clk);
      chk("s1_dir", 32'(dir), 32'd3);
      chk("s1_sb_empty", 32'(sb.size()), 32'd0);
      run = 1'b0;
      repeat (12) @(negedge Clk);
      chk("s1_cnt_hold", 32'(dut.r_move_cnt), 32'd0);
      chk("s1_no_tick_idle", 32'(sb.size()), 32'd0);

      // Glitch rejected, then a clean up press
      run = 1'b1;
      t0  = cyc;
      push(t0 + 10, 2'b11, 1'b0);
      push(t0 + 20, 2'b00, 1'b1);
      BtnU = 1'b1;
      repeat (3) @(negedge Clk);
      BtnU = 1'b0;
      repeat (3) @(negedge Clk);
      chk("s2_glitch_pending", 32'(dut.r_pending), 32'd3);
      BtnU = 1'b1;
      repeat (6) @(negedge Clk);
      BtnU = 1'b0;
      repeat (2) @(negedge Clk);
      chk("s2_press_pending", 32'(dut.r_pending), 32'd0);
      repeat (11) @(negedge Clk);
      chk("s2_sb_empty", 32'(sb.size()), 32'd0);
      chk("s2_dir", 32'(dir), 32'd0);
      run = 1'b0;

      // Up and down together: up wins
      do_reset();
      run = 1'b1;
      t0  = cyc;
      push(t0 + 10, 2'b00, 1'b1);
      BtnU = 1'b1;
      BtnD = 1'b1;
      repeat (6) @(negedge Clk);
      BtnU = 1'b0;
      BtnD = 1'b0;
      repeat (6) @(negedge Clk);
      chk("s3_sb_empty", 32'(sb.size()), 32'd0);
      chk("s3_dir", 32'(dir), 32'd0);
      run = 1'b0;

      // Up then left within one period: left is latest
      do_reset();
      run = 1'b1;
      t0  = cyc;
      push(t0 + 10, 2'b10, 1'b1);
      BtnU = 1'b1;
      repeat (2) @(negedge Clk);
      BtnL = 1'b1;
      repeat (4) @(negedge Clk);
      BtnU = 1'b0;
      repeat (2) @(negedge Clk);
      BtnL = 1'b0;
      repeat (4) @(negedge Clk);
      chk("s4_sb_empty", 32'(sb.size()), 32'd0);
      chk("s4_dir", 32'(dir), 32'd2);
      run = 1'b0;

      // Reversal from right to left
`ifdef SNAKE_REVERSE_LOCK_EN
      rev_dir = 2'b11;
      rev_chg = 1'b0;
`else
      rev_dir = 2'b10;
      rev_chg = 1'b1;
`endif
      do_reset();
      run = 1'b1;
      t0  = cyc;
      push(t0 + 10, rev_dir, rev_chg);
      BtnL = 1'b1;
      repeat (6) @(negedge Clk);
      BtnL = 1'b0;
      repeat (6) @(negedge Clk);
      chk("s5_sb_empty", 32'(sb.size()), 32'd0);
      chk("s5_dir", 32'(dir), 32'(rev_dir));
      run = 1'b0;

      // Press while idle is dropped; reset mid-period restarts the period
      do_reset();
      BtnU = 1'b1;
      repeat (6) @(negedge Clk);
      BtnU = 1'b0;
      repeat (4) @(negedge Clk);
      chk("s6_idle_pending", 32'(dut.r_pending), 32'd3);
      run = 1'b1;
      t0  = cyc;
      push(t0 + 10, 2'b11, 1'b0);
      repeat (10) @(negedge Clk);
      BtnD = 1'b1;
      repeat (4) @(negedge Clk);
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      chk("s6_rst_dir", 32'(dir), 32'd3);
      chk("s6_rst_cnt", 32'(dut.r_move_cnt), 32'd0);
      chk("s6_rst_tick", 32'(move_tick), 32'd0);
      chk("s6_rst_pending", 32'(dut.r_pending), 32'd3);
      Reset = 1'b0;
      BtnD  = 1'b0;
      t1    = cyc;
      push(t1 + 10, 2'b11, 1'b0);
      repeat (15) @(negedge Clk);
      chk("s6_sb_empty", 32'(sb.size()), 32'd0);
      chk("s6_dir", 32'(dir), 32'd3);
      run = 1'b0;
      repeat (2) @(negedge Clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/snake_dir_ctrl.md
SNAKE_DIR_CTRL -- requirements
Module: snake_dir_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable-high clocks before a press is accepted (5 ms at 100 MHz).
REQ-002 Parameter MOVE_PERIOD, default 15000000, is the number of clocks between snake moves (150 ms at 100 MHz).
REQ-003 Port Clk, input, 1 bit: system clock at 100 MHz; one clock domain; all state updates on its rising edge.
REQ-004 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port run, input, 1 bit: high while the game FSM is in its run state.
REQ-006 Ports BtnU, BtnD, BtnL and BtnR, input, 1 bit each: raw, asynchronous push buttons.
REQ-007 Port dir, output, 2 bits: committed heading; 00 = up, 01 = down, 10 = left, 11 = right.
REQ-008 Port move_tick, output, 1 bit: one-cycle pulse telling the snake core to advance one cell in dir.
REQ-009 Port dir_changed, output, 1 bit: one-cycle pulse, coincident with move_tick, when that tick changed dir.

Function
REQ-010 Each button shall pass through a 2-flop synchronizer before any other logic uses it.
REQ-011 Debounce: a per-button counter shall increment while the synced button is high, saturating at DEBOUNCE_CYCLES, and clear to 0 on any low sample.
REQ-012 Press detection: a press pulse shall fire exactly one cycle, on the cycle the counter first reaches DEBOUNCE_CYCLES; no repeat while the button is held.
REQ-013 Simultaneous presses: if several press pulses fire in the same cycle, only one shall be taken, with priority U > D > L > R.
REQ-014 Accepted press: the selected press shall write register pending only when run = 1; presses while run = 0 are discarded.
REQ-015 Newer accepted presses shall overwrite pending; only the latest accepted press before a tick counts.
REQ-016 Move counter: move_cnt shall count 0..MOVE_PERIOD-1 while run = 1 and wrap to 0 after MOVE_PERIOD-1.
REQ-017 move_cnt shall hold at 0 while run = 0.
REQ-018 move_tick shall be registered and asserted in the cycle after move_cnt = MOVE_PERIOD-1 with run = 1.
REQ-019 Period: the first tick after run rises shall occur MOVE_PERIOD clocks after the rise; later ticks every MOVE_PERIOD clocks.
REQ-020 Commit: on the cycle move_tick is asserted, dir shall load the pending value from the previous cycle.
REQ-021 A press accepted in the same cycle as a tick shall update pending only and take effect at the next tick.
REQ-022 dir_changed shall equal move_tick AND (new dir != old dir).
REQ-023 If run falls mid-period, move_cnt shall clear, no tick shall fire, and dir and pending shall be kept.

Reset
REQ-024 While Reset = 1: dir = 11 (right), pending = 11, move_cnt = 0, debounce counters = 0, synchronizers = 0, move_tick = 0, dir_changed = 0.
REQ-025 Reset shall take priority over run and all button activity, including a reset asserted mid-period or mid-debounce.

Configuration
REQ-026 With macro SNAKE_REVERSE_LOCK_EN defined, a press opposite the committed dir (U vs D, L vs R) shall be discarded and pending shall not change.
REQ-027 Without SNAKE_REVERSE_LOCK_EN, reversals shall be accepted like any other press; the snake core then detects the resulting self-collision.

Verification
(Parameters DEBOUNCE_CYCLES = 4 and MOVE_PERIOD = 10 for all scenarios.)
REQ-028 Reset, then run = 1 for 35 clocks -> dir = 11 throughout; ticks at clocks 10, 20 and 30 after run rises; dir_changed never asserted.
REQ-029 Debounce: BtnU high 3 clocks then low (glitch) -> pending unchanged; BtnU high 6 clocks -> one press, and the next tick gives dir = 00 with dir_changed = 1.
REQ-030 Simultaneous press: BtnU and BtnD high together, dir = 11 -> up wins; next tick gives dir = 00.
REQ-031 Last press wins: BtnU then BtnL both within one period -> next tick gives dir = 10.
REQ-032 Reversal with SNAKE_REVERSE_LOCK_EN: dir = 11, press BtnL -> dir stays 11 at the next tick. Without the macro: dir = 10 at the next tick.
REQ-033 Press while run = 0 -> ignored. Reset pulsed mid-period -> dir = 11, move_cnt = 0, and the next tick is exactly 10 clocks after Reset falls with run = 1.
